// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction bank port, branch redirect input
// and the decode-facing instruction output with halt/fault status.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;
    logic        fault;

    modport master (
        output imem_addr, instr, instr_pc, instr_valid, halted, fault,
        input  imem_data, id_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_addr, instr, instr_pc, instr_valid, halted, fault,
        output imem_data, id_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one registered bank read in flight, output register plus
// skid buffer against decode stalls, branch redirects, halt detection and fetch faults.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] ADDR_LIMIT  = 32'd252,
    parameter logic [5:0]  HALT_OPCODE = 6'b101100
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED, FAULT} state_t;

    state_t      state, state_next;
    logic [31:0] pc, rsp_pc;
    logic        rsp_pending;
    logic [31:0] out_instr, out_pc;
    logic        out_valid;
    logic [31:0] skid_instr, skid_pc;
    logic        skid_valid;

    logic active, redirect, halt_rsp, pc_legal, transfer;
    logic take_rsp, out_free, skid_hold, attempt, issue, fault_now;

    assign active    = (state == RUN) || (state == DRAIN);
    assign redirect  = bus.redirect_valid && active;
    assign halt_rsp  = rsp_pending && (bus.imem_data[31:26] == HALT_OPCODE);
    assign pc_legal  = (pc[1:0] == 2'b00) && (pc <= ADDR_LIMIT);
    assign transfer  = out_valid && bus.id_ready && !bus.redirect_valid;
    assign take_rsp  = rsp_pending && active && !bus.redirect_valid;
    assign out_free  = !out_valid || transfer;

    // Gate issue on the skid's next-cycle occupancy: a stall then parks at most one
    // word in the skid, and a released stall can issue in the same cycle it drains.
    assign skid_hold = take_rsp ? (skid_valid || !out_free) : (skid_valid && !transfer);
    assign attempt   = (state == RUN) && !skid_hold && !bus.redirect_valid && !halt_rsp;
    assign issue     = attempt && pc_legal;
    assign fault_now = attempt && !pc_legal;

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (bus.redirect_valid) state_next = RUN;
                else if (fault_now)     state_next = FAULT;
                else if (halt_rsp)      state_next = DRAIN;
            end
            DRAIN: begin
                if (bus.redirect_valid) state_next = RUN;
                else if (transfer && out_instr[31:26] == HALT_OPCODE) state_next = HALTED;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pending <= 1'b0;
            rsp_pc      <= '0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_valid   <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            skid_valid  <= 1'b0;
        end else if (redirect) begin
            pc          <= bus.redirect_target;
            rsp_pending <= 1'b0;
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
        end else begin
            rsp_pending <= issue;
            if (issue) begin
                rsp_pc <= pc;
                pc     <= pc + 32'd4;
            end
            if (take_rsp) begin
                if (out_free) begin
                    out_valid <= 1'b1;
                    if (skid_valid) begin
                        out_instr  <= skid_instr;
                        out_pc     <= skid_pc;
                        skid_instr <= bus.imem_data;
                        skid_pc    <= rsp_pc;
                    end else begin
                        out_instr <= bus.imem_data;
                        out_pc    <= rsp_pc;
                    end
                end else begin
                    skid_valid <= 1'b1;
                    skid_instr <= bus.imem_data;
                    skid_pc    <= rsp_pc;
                end
            end else if (transfer) begin
                if (skid_valid) begin
                    out_instr  <= skid_instr;
                    out_pc     <= skid_pc;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.instr       = out_instr;
    assign bus.instr_pc    = out_pc;
    assign bus.instr_valid = out_valid;
    assign bus.halted      = (state == HALTED);
    assign bus.fault       = (state == FAULT);
endmodule
